cpu_bus_bridge: RTL and testbench

CPU_BUS_BRIDGE -- requirements
Module: cpu_bus_bridge

---
 rtl/bridge_pkg.sv | 20 ++
 rtl/bridge_arbiter.sv | 34 +++
 rtl/cpu_bus_bridge.sv | 116 +++++++++++
 tb/tb_cpu_bus_bridge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared FSM state, access size codes and segment constants for cpu_bus_bridge
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

endpackage

// File: rtl/bridge_arbiter.sv
// rtl/bridge_arbiter.sv - fixed-priority / round-robin channel arbiter
module bridge_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  input  logic              rr_mode_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Search starts at ptr_i in round-robin mode, at channel 0 otherwise.
  always_comb begin
    int   c;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = rr_mode_i ? int'(ptr_i) + i : i;
      if (c >= NUM_CH) c = c - NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && (c == j) && req_i[j]) begin
          found      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cpu_bus_bridge.sv
// rtl/cpu_bus_bridge.sv - multi-channel core bus to single SRAM-like port bridge
// Define ADDR_MAP_EN to fold kseg0/kseg1 virtual addresses onto physical space.
module cpu_bus_bridge #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [2*NUM_CH-1:0]      ch_size,
  input  logic [32*NUM_CH-1:0]     ch_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_addr_ok,
  output logic [NUM_CH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     m_req,
  output logic                     m_wr,
  output logic [1:0]               m_size,
  output logic [31:0]              m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_addr_ok,
  input  logic                     m_data_ok,
  input  logic [DATA_W-1:0]        m_rdata
);
  import bridge_pkg::*;

  localparam int   IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic RR_MODE = (ARB_MODE != 0);

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q, ptr_d, gnt_idx_q, arb_idx;
  logic [NUM_CH-1:0] arb_grant;
  logic              m_req_q, wr_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q, sel_addr, mapped_addr;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, resp_done;

  bridge_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arbiter (
    .req_i     (ch_req),
    .ptr_i     (ptr_q),
    .rr_mode_i (RR_MODE),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx)
  );

  assign accept    = (state_q == ST_IDLE) && (|ch_req) && !rst;
  assign resp_done = (state_q == ST_RESP) && m_data_ok && !rst;
  assign sel_addr  = ch_addr[32*int'(arb_idx) +: 32];

`ifdef ADDR_MAP_EN
  assign mapped_addr = ((sel_addr[31:29] == KSEG0) || (sel_addr[31:29] == KSEG1))
                       ? {3'b000, sel_addr[28:0]} : sel_addr;
`else
  assign mapped_addr = sel_addr;
`endif

  assign ptr_d = (gnt_idx_q == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      m_req_q   <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q   <= ST_REQ;
            m_req_q   <= 1'b1;
            gnt_idx_q <= arb_idx;
            wr_q      <= ch_wr[arb_idx];
            size_q    <= ch_size[2*int'(arb_idx) +: 2];
            addr_q    <= mapped_addr;
            wdata_q   <= ch_wdata[DATA_W*int'(arb_idx) +: DATA_W];
          end
        end
        ST_REQ: begin
          if (m_addr_ok) begin
            state_q <= ST_RESP;
            m_req_q <= 1'b0;
          end
        end
        ST_RESP: begin
          if (m_data_ok) begin
            state_q <= ST_IDLE;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request fields are only presented while the downstream request is live.
  assign m_req   = m_req_q;
  assign m_wr    = m_req_q & wr_q;
  assign m_size  = m_req_q ? size_q  : '0;
  assign m_addr  = m_req_q ? addr_q  : '0;
  assign m_wdata = m_req_q ? wdata_q : '0;

  assign ch_addr_ok = accept    ? arb_grant                   : '0;
  assign ch_data_ok = resp_done ? (NUM_CH'(1) << gnt_idx_q)   : '0;
  assign ch_rdata   = resp_done ? m_rdata                     : '0;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb/tb_cpu_bus_bridge.sv - scoreboard bench for cpu_bus_bridge (round-robin and fixed-priority instances)
module tb_cpu_bus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  ch_req = 2'b00;
  logic        f_wr[2];
  logic [1:0]  f_size[2];
  logic [31:0] f_addr[2];
  logic [31:0] f_wdata[2];
  logic [1:0]  ch_wr, ch_size_lo, ch_size_hi;
  logic [63:0] ch_addr, ch_wdata;
  assign ch_wr      = {f_wr[1], f_wr[0]};
  assign ch_size_lo = f_size[0];
  assign ch_size_hi = f_size[1];
  assign ch_addr    = {f_addr[1], f_addr[0]};
  assign ch_wdata   = {f_wdata[1], f_wdata[0]};

  logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  logic [1:0]  ch_addr_ok, ch_data_ok, fp_addr_ok, fp_data_ok;
  logic [31:0] ch_rdata, fp_rdata, m_addr, fp_m_addr, m_wdata, fp_m_wdata;
  logic        m_req, m_wr, fp_m_req, fp_m_wr;
  logic [1:0]  m_size, fp_m_size;

  cpu_bus_bridge #(.NUM_CH(2), .DATA_W(32), .ARB_MODE(1)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size({ch_size_hi, ch_size_lo}),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
    .ch_rdata(ch_rdata), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  cpu_bus_bridge #(.NUM_CH(2), .DATA_W(32), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size({ch_size_hi, ch_size_lo}),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(fp_addr_ok), .ch_data_ok(fp_data_ok),
    .ch_rdata(fp_rdata), .m_req(fp_m_req), .m_wr(fp_m_wr), .m_size(fp_m_size), .m_addr(fp_m_addr),
    .m_wdata(fp_m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0]  exp_acc[$];
  logic [1:0]  exp_fp[$];
  logic [66:0] exp_m[$];
  logic [33:0] exp_r[$];
  logic [31:0] rdata_q[$];

  logic resp_en   = 1'b1;
  int   addr_wait = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int ch);
    return (ch == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef ADDR_MAP_EN
    if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return {3'b000, a[28:0]};
`endif
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    f_wr[ch] = wr; f_size[ch] = size; f_addr[ch] = addr; f_wdata[ch] = wdata;
  endtask

  task automatic expect_xact(input int rr_ch, input int fp_ch, input logic [31:0] rdata);
    exp_acc.push_back(oh(rr_ch));
    exp_fp.push_back(oh(fp_ch));
    exp_m.push_back({f_wr[rr_ch], f_size[rr_ch], exp_addr(f_addr[rr_ch]), f_wdata[rr_ch]});
    exp_r.push_back({oh(rr_ch), rdata});
    rdata_q.push_back(rdata);
  endtask

  task automatic wait_acc();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ch_addr_ok === 2'b00 && t < 50);
    if (t >= 50) chk("accept_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_r.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("response_timeout", 1, 0);
    step();
  endtask

  task automatic run(input logic [1:0] mask, input int n);
    ch_req = mask;
    for (int k = 0; k < n; k++) wait_acc();
    step();
    ch_req = 2'b00;
    wait_idle();
  endtask

  // Downstream responder: addr_ok after addr_wait stall cycles, data_ok the cycle after.
  initial begin
    int   cnt = 0;
    logic pending = 1'b0;
    forever begin
      step();
      if (resp_en) begin
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        if (m_req) begin
          if (cnt < addr_wait) cnt++;
          else begin
            m_addr_ok = 1'b1;
            cnt       = 0;
            pending   = 1'b1;
          end
        end else if (pending) begin
          m_data_ok = 1'b1;
          m_rdata   = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
          pending   = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every DUT output event against the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (ch_addr_ok !== 2'b00) begin
        if (exp_acc.size() == 0) chk("accept_unexpected", ch_addr_ok, 0);
        else chk("accept_grant", ch_addr_ok, exp_acc.pop_front());
      end
      if (fp_addr_ok !== 2'b00) begin
        if (exp_fp.size() == 0) chk("fp_accept_unexpected", fp_addr_ok, 0);
        else chk("fp_accept_grant", fp_addr_ok, exp_fp.pop_front());
      end
      if (m_req !== 1'b0) begin
        if (exp_m.size() == 0) chk("mreq_unexpected", m_req, 0);
        else begin
          chk("mreq_fields", {m_wr, m_size, m_addr, m_wdata}, exp_m[0]);
          if (m_addr_ok) exp_m.delete(0);
        end
      end
      if (ch_data_ok !== 2'b00) begin
        if (exp_r.size() == 0) chk("resp_unexpected", {ch_data_ok, ch_rdata}, 0);
        else chk("resp_data", {ch_data_ok, ch_rdata}, exp_r.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int stall;
    for (int i = 0; i < 2; i++) set_ch(i, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_m_req",      m_req,      0);
    chk("reset_m_fields",   {m_wr, m_size, m_addr, m_wdata}, 0);
    chk("reset_ch_addr_ok", ch_addr_ok, 0);
    chk("reset_ch_data_ok", ch_data_ok, 0);
    chk("reset_ch_rdata",   ch_rdata,   0);
    chk("reset_fp_outputs", {fp_m_req, fp_addr_ok, fp_data_ok}, 0);
    step();

    // Continuous contention: round-robin alternates, fixed priority always picks ch0.
    set_ch(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0);
    set_ch(1, 1'b1, 2'd1, 32'h0000_2000, 32'h0000_55AA);
    expect_xact(0, 0, 32'h1111_0000);
    expect_xact(1, 0, 32'h2222_0001);
    expect_xact(0, 0, 32'h3333_0002);
    expect_xact(1, 0, 32'h4444_0003);
    run(2'b11, 4);

    // Single read with minimum latency.
    set_ch(0, 1'b0, 2'd2, 32'h8000_0100, 32'h0);
    expect_xact(0, 0, 32'hDEAD_BEEF);
    ch_req = 2'b01;
    wait_acc();
    step();
    ch_req = 2'b00;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ch_data_ok === 2'b00 && lat < 20);
    chk("single_read_latency", lat, 2);
    wait_idle();

    // Write through kseg1.
    set_ch(1, 1'b1, 2'd2, 32'hA000_0004, 32'h1234_5678);
    expect_xact(1, 1, 32'h0);
    run(2'b10, 1);

    // Reserved size code and an unmapped segment.
    set_ch(1, 1'b0, 2'd3, 32'hC000_3000, 32'hCAFE_0000);
    expect_xact(1, 1, 32'h0BAD_F00D);
    run(2'b10, 1);

    // Backpressure: five stalled cycles, ch1 requesting meanwhile must not be accepted.
    addr_wait = 5;
    set_ch(0, 1'b1, 2'd0, 32'h9FFF_FFFC, 32'hA5A5_5A5A);
    expect_xact(0, 0, 32'h7777_7777);
    ch_req = 2'b01;
    wait_acc();
    step();
    ch_req = 2'b10;
    stall = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (m_addr_ok) break;
      if (m_req) stall++;
    end
    chk("backpressure_stall_cycles", stall, 5);
    step();
    ch_req = 2'b00;
    wait_idle();
    addr_wait = 0;

    // Reset while waiting for the response, then a late data_ok.
    resp_en = 1'b0;
    set_ch(1, 1'b0, 2'd2, 32'h8000_0200, 32'h0);
    exp_acc.push_back(2'b10);
    exp_fp.push_back(2'b10);
    exp_m.push_back({1'b0, 2'd2, exp_addr(32'h8000_0200), 32'h0});
    ch_req = 2'b10;
    wait_acc();
    step();
    ch_req    = 2'b00;
    m_addr_ok = 1'b1;
    step();
    m_addr_ok = 1'b0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    m_data_ok = 1'b1;
    m_rdata   = 32'hBADB_AD00;
    @(negedge clk);
    chk("late_data_ok_dropped", ch_data_ok, 0);
    chk("late_rdata_zero",      ch_rdata,   0);
    chk("after_reset_m_req",    m_req,      0);
    step();
    m_data_ok = 1'b0;
    resp_en   = 1'b1;

    // Pointer restarted at 0: with both requesting, ch0 wins.
    set_ch(0, 1'b0, 2'd2, 32'h0000_0040, 32'h0);
    expect_xact(0, 0, 32'h4444_4444);
    run(2'b11, 1);

    repeat (3) step();
    chk("accept_queue_drained", exp_acc.size(), 0);
    chk("fp_queue_drained",     exp_fp.size(),  0);
    chk("mreq_queue_drained",   exp_m.size(),   0);
    chk("resp_queue_drained",   exp_r.size(),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
